ws2812_rx: RTL and testbench

- Decodes a single-wire WS2812 serial stream back into 24-bit pixel words. It is the receive-side counterpart of the on-board ws2812 LED driver.
- Used for driver loopback checks and for emulating one pixel of a chain.
- Synchronises the asynchronous input and classifies each bit by its high-pulse width.
- Captures the word of one selected pixel and reports frame boundaries, pixel count and framing errors.

---
 rtl/ws2812_rx.sv | 188 ++++++++++++++++++
 tb/tb_ws2812_rx.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 serial receiver capturing one pixel word; WS2812_FWD_EN adds daisy-chain forwarding on dout
module ws2812_rx #(
  parameter int CLK_FRE      = 27_000_000,
  parameter int WS2812_WIDTH = 24,
  parameter int PIXEL_INDEX  = 0,
  parameter int BIT_THRESH   = CLK_FRE / 1000 * 625 / 1_000_000,
  parameter int MIN_HIGH     = CLK_FRE / 1000 * 100 / 1_000_000,
  parameter int MAX_HIGH     = CLK_FRE / 1000 * 1500 / 1_000_000,
  parameter int RESET_CNT    = CLK_FRE / 1000 * 50 / 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    din,
  output logic [WS2812_WIDTH-1:0] pixel_data,
  output logic                    pixel_valid,
  output logic                    frame_done,
  output logic [8:0]              pixel_count,
  output logic                    frame_err,
  output logic                    dout
);
  localparam int LW = $clog2(RESET_CNT + 1);
  localparam int BW = $clog2(WS2812_WIDTH);
  localparam logic [LW-1:0] LMAX = LW'(RESET_CNT);
  localparam logic [7:0] TH = 8'(BIT_THRESH);
  localparam logic [7:0] MN = 8'(MIN_HIGH);
  localparam logic [7:0] MX = 8'(MAX_HIGH);
  localparam logic [BW-1:0] LAST = BW'(WS2812_WIDTH - 1);
  localparam logic [8:0] OWN = 9'(PIXEL_INDEX);

  typedef enum logic [1:0] {RESYNC, IDLE, HIGH, LOW} state_t;

  state_t state_q, state_d;
  logic s1_q, s2_q, d_q;
  logic [7:0] hcnt_q, hcnt_d;
  logic [LW-1:0] lcnt_q, lcnt_d, lcnt_inc;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [8:0] pix_cnt_q, pix_cnt_d;
  logic [WS2812_WIDTH-1:0] shift_q, shift_d, shift_bit;
  logic pv_q, pv_d, fd_q, fd_d, fe_q, fe_d;
  logic rise, fall, bit_val, last_bit;
  logic [WS2812_WIDTH-1:0] pixel_data_q;
  logic pixel_valid_q, frame_done_q, frame_err_q;
  logic [8:0] pixel_count_q;

  // two-flop synchroniser plus delayed copy for edge detection
  always_ff @(posedge clk) begin
    s1_q <= reset ? 1'b0 : din;
    s2_q <= reset ? 1'b0 : s1_q;
    d_q  <= reset ? 1'b0 : s2_q;
  end

  // edge classification, saturating low count and the word with the current bit inserted
  always_comb begin
    rise = s2_q & ~d_q;
    fall = ~s2_q & d_q;
    bit_val = hcnt_q > TH;
    last_bit = bit_cnt_q == LAST;
    lcnt_inc = (lcnt_q == LMAX) ? lcnt_q : lcnt_q + LW'(1);
    shift_bit = shift_q;
    shift_bit[bit_cnt_q] = bit_val;
  end

  // decoder next-state: pulse-width classification, pixel assembly and frame boundaries
  always_comb begin
    state_d = state_q;
    hcnt_d = hcnt_q;
    lcnt_d = lcnt_q;
    bit_cnt_d = bit_cnt_q;
    pix_cnt_d = pix_cnt_q;
    shift_d = shift_q;
    pv_d = 1'b0;
    fd_d = 1'b0;
    fe_d = 1'b0;
    case (state_q)
      RESYNC: begin
        lcnt_d = s2_q ? '0 : lcnt_inc;
        state_d = (!s2_q && lcnt_inc == LMAX) ? IDLE : RESYNC;
      end
      IDLE: if (rise) begin
        bit_cnt_d = '0;
        pix_cnt_d = '0;
        shift_d = '0;
        hcnt_d = 8'd1;
        state_d = HIGH;
      end
      HIGH: begin
        if (s2_q) begin
          if (hcnt_q == 8'hff) begin
            fe_d = 1'b1;
            lcnt_d = '0;
            state_d = RESYNC;
          end else hcnt_d = hcnt_q + 8'd1;
        end else if (fall) begin
          if (hcnt_q < MN) begin
            lcnt_d = '0;
            state_d = LOW;
          end else if (hcnt_q > MX) begin
            fe_d = 1'b1;
            lcnt_d = '0;
            state_d = RESYNC;
          end else begin
            shift_d = shift_bit;
            bit_cnt_d = last_bit ? '0 : bit_cnt_q + BW'(1);
            lcnt_d = LW'(1);
            state_d = LOW;
            if (last_bit) begin
              pv_d = pix_cnt_q == OWN;
              pix_cnt_d = (&pix_cnt_q) ? pix_cnt_q : pix_cnt_q + 9'd1;
            end
          end
        end
      end
      LOW: begin
        if (rise) begin
          hcnt_d = 8'd1;
          state_d = HIGH;
        end else begin
          lcnt_d = lcnt_inc;
          if (lcnt_inc == LMAX) begin
            fd_d = 1'b1;
            fe_d = bit_cnt_q != '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = RESYNC;
    endcase
  end

  // decoder state and event strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RESYNC;
      hcnt_q <= '0;
      lcnt_q <= '0;
      bit_cnt_q <= '0;
      pix_cnt_q <= '0;
      shift_q <= '0;
      pv_q <= 1'b0;
      fd_q <= 1'b0;
      fe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q <= hcnt_d;
      lcnt_q <= lcnt_d;
      bit_cnt_q <= bit_cnt_d;
      pix_cnt_q <= pix_cnt_d;
      shift_q <= shift_d;
      pv_q <= pv_d;
      fd_q <= fd_d;
      fe_q <= fe_d;
    end
  end

  // output register; shift and pix_cnt are still stable the cycle after their strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_data_q <= '0;
      pixel_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      pixel_count_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      pixel_data_q <= pv_q ? shift_q : pixel_data_q;
      pixel_valid_q <= pv_q;
      frame_done_q <= fd_q;
      pixel_count_q <= fd_q ? pix_cnt_q : pixel_count_q;
      frame_err_q <= fe_q;
    end
  end

  assign pixel_data = pixel_data_q;
  assign pixel_valid = pixel_valid_q;
  assign frame_done = frame_done_q;
  assign pixel_count = pixel_count_q;
  assign frame_err = frame_err_q;

`ifdef WS2812_FWD_EN
  logic gate_q;

  // forward gate opens once our pixel is complete and closes at frame end or on any error
  always_ff @(posedge clk) gate_q <= reset ? 1'b0 : pv_d ? 1'b1 : (fd_d | fe_d) ? 1'b0 : gate_q;

  assign dout = gate_q & s2_q;
`else
  assign dout = 1'b0;
`endif
endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: randomized self-checking bench for ws2812_rx (PIXEL_INDEX 0 and 2 instances)
module tb_ws2812_rx;
  localparam int RESET_CNT = 1350;
  localparam int GAP = 1400;
`ifdef WS2812_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1, din = 1'b0;
  logic [23:0] pd0, pd2;
  logic pv0, fd0, fe0, do0, pv2, fd2, fe2, do2;
  logic [8:0] pc0, pc2;

  int checks = 0, errors = 0;
  int pv0_n = 0, fd0_n = 0, fe0_n = 0, fefd0_n = 0, pv2_n = 0, fd2_n = 0, do0_n = 0, do2_n = 0;
  logic [23:0] pd0_l = '0, pd2_l = '0;
  logic [8:0] pc0_l = '0, pc2_l = '0;
  int hi_acc = 0;
  logic [23:0] m_pd2 = '0;

  always #5 clk = ~clk;

  ws2812_rx dut (.clk(clk), .reset(reset), .din(din), .pixel_data(pd0), .pixel_valid(pv0),
                 .frame_done(fd0), .pixel_count(pc0), .frame_err(fe0), .dout(do0));
  ws2812_rx #(.PIXEL_INDEX(2)) dut2 (.clk(clk), .reset(reset), .din(din), .pixel_data(pd2), .pixel_valid(pv2),
                 .frame_done(fd2), .pixel_count(pc2), .frame_err(fe2), .dout(do2));

  always @(negedge clk) begin
    if (pv0) begin pv0_n++; pd0_l = pd0; end
    if (fd0) begin fd0_n++; pc0_l = pc0; end
    if (fe0) fe0_n++;
    if (fe0 && fd0) fefd0_n++;
    if (pv2) begin pv2_n++; pd2_l = pd2; end
    if (fd2) begin fd2_n++; pc2_l = pc2; end
    if (do0) do0_n++;
    if (do2) do2_n++;
  end

  task automatic hold(input logic v, input int n);
    din = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit rnd);
    int hi, lo;
    hi = rnd ? (b ? int'($urandom_range(40, 17)) : int'($urandom_range(16, 2))) : (b ? 23 : 11);
    lo = rnd ? int'($urandom_range(40, 3)) : (b ? 11 : 23);
    hi_acc += hi;
    hold(1'b1, hi);
    hold(1'b0, lo);
  endtask

  task automatic send_bits(input logic [23:0] w, input int nb, input bit rnd);
    for (int i = 0; i < nb; i++) send_bit(w[i], rnd);
  endtask

  task automatic test_reset();
    int v0, f0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({pd0, pv0, fd0, pc0, fe0, do0} !== 38'd0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", {pd0, pv0, fd0, pc0, fe0, do0});
    end
    reset = 1'b0;
    v0 = pv0_n; f0 = fd0_n;
    send_bits(24'h5a5a5a, 24, 1'b0);
    hold(1'b0, GAP);
    checks++;
    if (pv0_n - v0 !== 0) begin errors++; $display("FAIL resync_pv got %0d exp 0", pv0_n - v0); end
    checks++;
    if (fd0_n - f0 !== 0) begin errors++; $display("FAIL resync_fd got %0d exp 0", fd0_n - f0); end
  endtask

  task automatic test_single();
    int v0 = pv0_n, f0 = fd0_n, e0 = fe0_n, v2 = pv2_n;
    send_bits(24'ha5c3f0, 24, 1'b0);
    hold(1'b0, GAP);
    checks++;
    if (pv0_n - v0 !== 1) begin errors++; $display("FAIL single_pv got %0d exp 1", pv0_n - v0); end
    checks++;
    if (pd0_l !== 24'ha5c3f0) begin errors++; $display("FAIL single_data got %h exp a5c3f0", pd0_l); end
    checks++;
    if (fd0_n - f0 !== 1 || pc0_l !== 9'd1) begin
      errors++; $display("FAIL single_frame got fd %0d cnt %0d exp fd 1 cnt 1", fd0_n - f0, pc0_l);
    end
    checks++;
    if (fe0_n - e0 !== 0) begin errors++; $display("FAIL single_err got %0d exp 0", fe0_n - e0); end
    checks++;
    if (pv2_n - v2 !== 0 || pc2_l !== 9'd1) begin
      errors++; $display("FAIL single_idx2 got pv %0d cnt %0d exp pv 0 cnt 1", pv2_n - v2, pc2_l);
    end
  endtask

  task automatic test_latency();
    logic [23:0] w;
    w = 24'($urandom);
    send_bits(w, 23, 1'b0);
    hold(1'b1, w[23] ? 23 : 11);
    din = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pv0 !== 1'b0) begin errors++; $display("FAIL lat_pv_early got %b exp 0", pv0); end
    @(posedge clk);
    #1;
    checks++;
    if (pv0 !== 1'b1 || pd0 !== w) begin
      errors++; $display("FAIL lat_pv got pv %b data %h exp pv 1 data %h", pv0, pd0, w);
    end
    repeat (RESET_CNT - 2) @(posedge clk);
    #1;
    checks++;
    if (fd0 !== 1'b0) begin errors++; $display("FAIL lat_fd_early got %b exp 0", fd0); end
    @(posedge clk);
    #1;
    checks++;
    if (fd0 !== 1'b1 || pc0 !== 9'd1 || fe0 !== 1'b0) begin
      errors++; $display("FAIL lat_fd got fd %b cnt %0d err %b exp fd 1 cnt 1 err 0", fd0, pc0, fe0);
    end
    hold(1'b0, 20);
  endtask

  task automatic test_multi();
    logic [23:0] w [4];
    int v0 = pv0_n, v2 = pv2_n, o0 = do0_n, o2 = do2_n, e0 = fe0_n, x0 = 0, x2 = 0;
    w = '{24'h000001, 24'h000002, 24'h000003, 24'h000004};
    for (int k = 0; k < 4; k++) begin
      hi_acc = 0;
      send_bits(w[k], 24, 1'b0);
      if (k > 0) x0 += hi_acc;
      if (k > 2) x2 += hi_acc;
    end
    hold(1'b0, GAP);
    m_pd2 = w[2];
    checks++;
    if (pv2_n - v2 !== 1 || pd2_l !== 24'h000003) begin
      errors++; $display("FAIL multi_idx2 got pv %0d data %h exp pv 1 data 000003", pv2_n - v2, pd2_l);
    end
    checks++;
    if (pv0_n - v0 !== 1 || pd0_l !== 24'h000001) begin
      errors++; $display("FAIL multi_idx0 got pv %0d data %h exp pv 1 data 000001", pv0_n - v0, pd0_l);
    end
    checks++;
    if (pc0_l !== 9'd4 || pc2_l !== 9'd4) begin
      errors++; $display("FAIL multi_count got %0d/%0d exp 4/4", pc0_l, pc2_l);
    end
    checks++;
    if (fe0_n - e0 !== 0) begin errors++; $display("FAIL multi_err got %0d exp 0", fe0_n - e0); end
    checks++;
    if (do0_n - o0 !== (FWD ? x0 : 0) || do2_n - o2 !== (FWD ? x2 : 0)) begin
      errors++; $display("FAIL multi_dout got %0d/%0d exp %0d/%0d", do0_n - o0, do2_n - o2, FWD ? x0 : 0, FWD ? x2 : 0);
    end
  endtask

  task automatic test_partial();
    logic [23:0] w0, w1;
    int f0 = fd0_n, e0 = fe0_n, c0 = fefd0_n, v2 = pv2_n;
    w0 = 24'($urandom);
    w1 = 24'($urandom);
    send_bits(w0, 24, 1'b1);
    send_bits(w1, 6, 1'b1);
    hold(1'b0, GAP);
    checks++;
    if (pd0_l !== w0 || pc0_l !== 9'd1) begin
      errors++; $display("FAIL partial_pix got data %h cnt %0d exp data %h cnt 1", pd0_l, pc0_l, w0);
    end
    checks++;
    if (fd0_n - f0 !== 1 || fe0_n - e0 !== 1 || fefd0_n - c0 !== 1) begin
      errors++; $display("FAIL partial_err got fd %0d err %0d both %0d exp 1 1 1", fd0_n - f0, fe0_n - e0, fefd0_n - c0);
    end
    checks++;
    if (pv2_n - v2 !== 0 || pd2 !== m_pd2) begin
      errors++; $display("FAIL partial_hold got pv %0d data %h exp pv 0 data %h", pv2_n - v2, pd2, m_pd2);
    end
  endtask

  task automatic test_glitch();
    logic [23:0] w = 24'h123456;
    int v0 = pv0_n, e0 = fe0_n, c0 = fefd0_n;
    for (int i = 0; i < 24; i++) begin
      send_bit(w[i], 1'b0);
      hold(1'b1, 1);
      hold(1'b0, 5);
    end
    hold(1'b0, GAP);
    checks++;
    if (pv0_n - v0 !== 1 || pd0_l !== 24'h123456) begin
      errors++; $display("FAIL glitch_data got pv %0d data %h exp pv 1 data 123456", pv0_n - v0, pd0_l);
    end
    checks++;
    if (fe0_n - e0 !== 0 || pc0_l !== 9'd1) begin
      errors++; $display("FAIL glitch_err got err %0d cnt %0d exp err 0 cnt 1", fe0_n - e0, pc0_l);
    end
    v0 = pv0_n;
    send_bits(24'hffffff, 23, 1'b0);
    hold(1'b1, 1);
    hold(1'b0, GAP);
    checks++;
    if (pv0_n - v0 !== 0 || pc0_l !== 9'd0 || fefd0_n - c0 !== 1) begin
      errors++; $display("FAIL glitch_last got pv %0d cnt %0d errfd %0d exp 0 0 1", pv0_n - v0, pc0_l, fefd0_n - c0);
    end
  endtask

  task automatic test_stuck();
    logic [23:0] w, w2;
    int v0 = pv0_n, f0 = fd0_n, e0 = fe0_n;
    w = 24'($urandom);
    w2 = 24'($urandom);
    send_bits(w, 10, 1'b1);
    hold(1'b1, 60);
    hold(1'b0, 10);
    send_bits(w, 14, 1'b1);
    hold(1'b0, GAP);
    checks++;
    if (fe0_n - e0 !== 1 || fd0_n - f0 !== 0 || pv0_n - v0 !== 0) begin
      errors++; $display("FAIL stuck_width got err %0d fd %0d pv %0d exp 1 0 0", fe0_n - e0, fd0_n - f0, pv0_n - v0);
    end
    hold(1'b1, 300);
    hold(1'b0, GAP);
    checks++;
    if (fe0_n - e0 !== 2 || fd0_n - f0 !== 0) begin
      errors++; $display("FAIL stuck_sat got err %0d fd %0d exp 2 0", fe0_n - e0, fd0_n - f0);
    end
    send_bits(w2, 24, 1'b1);
    hold(1'b0, GAP);
    checks++;
    if (pv0_n - v0 !== 1 || pd0_l !== w2 || pc0_l !== 9'd1 || fe0_n - e0 !== 2) begin
      errors++; $display("FAIL stuck_recover got pv %0d data %h cnt %0d exp pv 1 data %h cnt 1", pv0_n - v0, pd0_l, pc0_l, w2);
    end
  endtask

  task automatic test_reset_mid();
    logic [23:0] w2;
    int v0 = pv0_n, f0 = fd0_n, e0 = fe0_n;
    w2 = 24'($urandom);
    send_bits(24'($urandom), 12, 1'b1);
    reset = 1'b1;
    hold(1'b0, 2);
    reset = 1'b0;
    m_pd2 = '0;
    checks++;
    if (pd0 !== 24'd0 || pd2 !== m_pd2) begin
      errors++; $display("FAIL rstmid_clear got %h/%h exp 0/0", pd0, pd2);
    end
    hold(1'b0, GAP);
    send_bits(w2, 24, 1'b1);
    hold(1'b0, GAP);
    checks++;
    if (pv0_n - v0 !== 1 || pd0_l !== w2 || fd0_n - f0 !== 1 || fe0_n - e0 !== 0) begin
      errors++; $display("FAIL rstmid_frame got pv %0d data %h fd %0d err %0d exp 1 %h 1 0", pv0_n - v0, pd0_l, fd0_n - f0, fe0_n - e0, w2);
    end
  endtask

  task automatic test_random();
    logic [23:0] ws [4];
    int n, x0, x2, v0, f0, e0, o0, o2;
    for (int f = 0; f < 3; f++) begin
      n = int'($urandom_range(4, 1));
      x0 = 0; x2 = 0;
      v0 = pv0_n; f0 = fd0_n; e0 = fe0_n; o0 = do0_n; o2 = do2_n;
      for (int k = 0; k < n; k++) begin
        ws[k] = (k == 0 && f < 2) ? 24'h00ff00 : 24'($urandom);
        hi_acc = 0;
        send_bits(ws[k], 24, 1'b1);
        if (k > 0) x0 += hi_acc;
        if (k > 2) x2 += hi_acc;
      end
      hold(1'b0, GAP);
      if (n > 2) m_pd2 = ws[2];
      checks++;
      if (pv0_n - v0 !== 1 || pd0_l !== ws[0]) begin
        errors++; $display("FAIL rand_data got pv %0d data %h exp pv 1 data %h", pv0_n - v0, pd0_l, ws[0]);
      end
      checks++;
      if (fd0_n - f0 !== 1 || pc0_l !== 9'(n) || pc2_l !== 9'(n) || fe0_n - e0 !== 0) begin
        errors++; $display("FAIL rand_frame got fd %0d cnt %0d/%0d err %0d exp 1 %0d 0", fd0_n - f0, pc0_l, pc2_l, fe0_n - e0, n);
      end
      checks++;
      if (pd2 !== m_pd2) begin errors++; $display("FAIL rand_idx2 got %h exp %h", pd2, m_pd2); end
      checks++;
      if (do0_n - o0 !== (FWD ? x0 : 0) || do2_n - o2 !== (FWD ? x2 : 0)) begin
        errors++; $display("FAIL rand_dout got %0d/%0d exp %0d/%0d", do0_n - o0, do2_n - o2, FWD ? x0 : 0, FWD ? x2 : 0);
      end
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_latency();
    test_multi();
    test_partial();
    test_glitch();
    test_stuck();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
